// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control constants: forward selects, FSM encoding, register index width.
package pipe_pkg;
    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_DIV_WAIT = 1'b1;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs and control outputs.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic [REG_AW-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic              mem_read_E, div_start_E, pc_src_E;
    logic              reg_write_M, dmem_req_M, dmem_ready, reg_write_W;
    logic              stall_F, stall_D, stall_E, stall_M;
    logic              flush_D, flush_E, flush_M, flush_W;
    logic [1:0]        forward_A_E, forward_B_E;
    logic              div_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
               mem_read_E, div_start_E, pc_src_E,
               reg_write_M, dmem_req_M, dmem_ready, reg_write_W,
        input  stall_F, stall_D, stall_E, stall_M,
               flush_D, flush_E, flush_M, flush_W,
               forward_A_E, forward_B_E, div_busy, stall_cnt
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
               mem_read_E, div_start_E, pc_src_E,
               reg_write_M, dmem_req_M, dmem_ready, reg_write_W,
        output stall_F, stall_D, stall_E, stall_M,
               flush_D, flush_E, flush_M, flush_W,
               forward_A_E, forward_B_E, div_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// E-stage operand forward select for one source register; M result beats W, x0 never forwarded.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs_E_i,
    input  logic [REG_AW-1:0] rd_M_i,
    input  logic              reg_write_M_i,
    input  logic [REG_AW-1:0] rd_W_i,
    input  logic              reg_write_W_i,
    output logic [1:0]        fwd_o
);
    always_comb begin
        fwd_o = FWD_RF;
        if (reg_write_M_i && rd_M_i != '0 && rd_M_i == rs_E_i)
            fwd_o = FWD_M;
        else if (reg_write_W_i && rd_W_i != '0 && rd_W_i == rs_E_i)
            fwd_o = FWD_W;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use, branch redirect, divide and memory waits.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    logic [0:0]       state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mem_wait, div_stall, load_use;
    logic [3:0] stall_v, flush_v;  // {F,D,E,M} and {D,E,M,W}

    assign mem_wait  = hz.dmem_req_M & ~hz.dmem_ready;
    assign div_stall = (state_q == ST_RUN && hz.div_start_E) ||
                       (state_q == ST_DIV_WAIT && div_cnt_q != '0);
    assign load_use  = hz.mem_read_E && hz.rd_E != '0 &&
                       (hz.rd_E == hz.rs1_D || hz.rd_E == hz.rs2_D);

    always_comb begin
        stall_v = 4'b0000;
        flush_v = 4'b0000;
        if (rst) begin
            flush_v = 4'b1111;
        end else if (mem_wait) begin
            stall_v = 4'b1111;
            flush_v = 4'b0001;
        end else if (div_stall) begin
            stall_v = 4'b1110;
            flush_v = 4'b0010;
        end else if (hz.pc_src_E) begin
            flush_v = 4'b1100;
        end else if (load_use) begin
            stall_v = 4'b1100;
            flush_v = 4'b0100;
        end
    end

    assign {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M} = stall_v;
    assign {hz.flush_D, hz.flush_E, hz.flush_M, hz.flush_W} = flush_v;
    assign hz.div_busy  = ~rst && state_q == ST_DIV_WAIT;
    assign hz.stall_cnt = cnt_q;

    logic [1:0] fwd_a, fwd_b;

    fwd_sel u_fwd_a (
        .rs_E_i(hz.rs1_E), .rd_M_i(hz.rd_M), .reg_write_M_i(hz.reg_write_M),
        .rd_W_i(hz.rd_W), .reg_write_W_i(hz.reg_write_W), .fwd_o(fwd_a)
    );
    fwd_sel u_fwd_b (
        .rs_E_i(hz.rs2_E), .rd_M_i(hz.rd_M), .reg_write_M_i(hz.reg_write_M),
        .rd_W_i(hz.rd_W), .reg_write_W_i(hz.reg_write_W), .fwd_o(fwd_b)
    );

    assign hz.forward_A_E = rst ? FWD_RF : fwd_a;
    assign hz.forward_B_E = rst ? FWD_RF : fwd_b;

    // Entry cycle in RUN plus DIV_CYCLES-1 cycles in DIV_WAIT (counting down to 0).
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        if (!mem_wait) begin
            if (state_q == ST_RUN) begin
                if (hz.div_start_E) begin
                    state_d   = ST_DIV_WAIT;
                    div_cnt_d = 8'(DIV_CYCLES - 2);
                end
            end else if (div_cnt_q != '0) begin
                div_cnt_d = div_cnt_q - 8'd1;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_v[3] && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            div_cnt_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule
